prog_loader: RTL and testbench

//   Writer side of the CPU program memory: receives a byte stream (valid/ready),

---
 rtl/prog_loader.sv | 158 +++++++++++++++
 tb/tb_prog_loader.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Program memory loader: unpacks a COUNT / commands / CHK byte frame into CMD_SIZE-bit words.
// It zero-fills the unused tail of the memory and holds the CPU in reset until a checked image is in place.
module prog_loader #(
  parameter int CMD_SIZE       = 19,
  parameter int PROG_SIZE      = 32,
  parameter int PROG_ADDR_SIZE = $clog2(PROG_SIZE)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      in_valid,
  input  logic [7:0]                in_data,
  output logic                      in_ready,
  output logic                      prog_we,
  output logic [PROG_ADDR_SIZE-1:0] prog_addr,
  output logic [CMD_SIZE-1:0]       prog_wdata,
  output logic                      cpu_reset,
  output logic                      done,
  output logic                      err
);

  localparam int                IDX_W     = PROG_ADDR_SIZE + 1;
  localparam int                B0_BITS   = CMD_SIZE - 16;
  localparam logic [7:0]        B0_MASK   = 8'((1 << B0_BITS) - 1);
  localparam logic [7:0]        SIZE_BYTE = 8'(PROG_SIZE);
  localparam logic [IDX_W-1:0]  FULL_IDX  = IDX_W'(PROG_SIZE);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(PROG_SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_CHECK,
    S_FILL,
    S_DONE,
    S_ERR
  } state_t;

  state_t             state;
  logic [1:0]         byte_cnt;
  logic [IDX_W-1:0]   word_idx;
  logic [IDX_W-1:0]   count_n;
  logic [7:0]         xor_acc;
  logic [B0_BITS-1:0] b0_low;
  logic [7:0]         b1;
  logic               xfer;

  assign xfer = in_valid & in_ready;

  // word_idx carries one extra bit so it can hold PROG_SIZE without wrapping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      in_ready   <= 1'b1;
      prog_we    <= 1'b0;
      prog_addr  <= '0;
      prog_wdata <= '0;
      cpu_reset  <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
      byte_cnt   <= 2'd0;
      word_idx   <= '0;
      count_n    <= '0;
      xor_acc    <= 8'd0;
      b0_low     <= '0;
      b1         <= 8'd0;
    end else begin
      prog_we <= 1'b0;
      if (start) begin
        state     <= S_IDLE;
        in_ready  <= 1'b1;
        cpu_reset <= 1'b1;
        done      <= 1'b0;
        err       <= 1'b0;
        byte_cnt  <= 2'd0;
        word_idx  <= '0;
        count_n   <= '0;
        xor_acc   <= 8'd0;
      end else begin
        case (state)
          S_IDLE: begin
            if (xfer) begin
              if (in_data == 8'd0 || in_data > SIZE_BYTE) begin
                state    <= S_ERR;
                in_ready <= 1'b0;
                err      <= 1'b1;
              end else begin
                count_n <= in_data[IDX_W-1:0];
                state   <= S_DATA;
              end
            end
          end
          S_DATA: begin
            if (xfer) begin
              xor_acc <= xor_acc ^ in_data;
              case (byte_cnt)
                2'd0: begin
                  if ((in_data & ~B0_MASK) != 8'd0) begin
                    state    <= S_ERR;
                    in_ready <= 1'b0;
                    err      <= 1'b1;
                  end else begin
                    b0_low   <= in_data[B0_BITS-1:0];
                    byte_cnt <= 2'd1;
                  end
                end
                2'd1: begin
                  b1       <= in_data;
                  byte_cnt <= 2'd2;
                end
                default: begin
                  prog_we    <= 1'b1;
                  prog_addr  <= word_idx[PROG_ADDR_SIZE-1:0];
                  prog_wdata <= {b0_low, b1, in_data};
                  word_idx   <= word_idx + IDX_W'(1);
                  byte_cnt   <= 2'd0;
                  if (word_idx == count_n - IDX_W'(1))
                    state <= S_CHECK;
                end
              endcase
            end
          end
          S_CHECK: begin
            if (xfer) begin
              in_ready <= 1'b0;
              if (in_data != xor_acc) begin
                state <= S_ERR;
                err   <= 1'b1;
              end else if (count_n == FULL_IDX) begin
                state <= S_DONE;
              end else begin
                state <= S_FILL;
              end
            end
          end
          S_FILL: begin
            prog_we    <= 1'b1;
            prog_addr  <= word_idx[PROG_ADDR_SIZE-1:0];
            prog_wdata <= '0;
            word_idx   <= word_idx + IDX_W'(1);
            if (word_idx == LAST_IDX)
              state <= S_DONE;
          end
          S_DONE: begin
            done      <= 1'b1;
            cpu_reset <= 1'b0;
          end
          S_ERR: begin
            err       <= 1'b1;
            cpu_reset <= 1'b1;
            in_ready  <= 1'b0;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected writes are queued as frames are driven.
// A negedge monitor pops the queue and compares each program memory write.
module tb_prog_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        prog_we;
  logic [4:0]  prog_addr;
  logic [18:0] prog_wdata;
  logic        cpu_reset;
  logic        done;
  logic        err;

  typedef struct {
    logic [4:0]  addr;
    logic [18:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  vectors;
  int  miscompares;

  prog_loader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_wdata (prog_wdata),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset && prog_we) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL unexpected_write got addr=%0d data=%h, expected no write", prog_addr, prog_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if (prog_addr !== mon_e.addr || prog_wdata !== mon_e.data) begin
          miscompares++;
          $display("[TB] FAIL write got addr=%0d data=%h, expected addr=%0d data=%h",
                   prog_addr, prog_wdata, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  task automatic push_wr(input int a, input logic [18:0] d);
    wr_t e;
    e.addr = 5'(a);
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int tries;
    repeat (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    tries    = 0;
    while (!in_ready && tries < 50) begin
      @(negedge clk);
      tries++;
    end
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL in_ready_timeout got in_ready=0, expected 1 for byte %h", b);
    end
    @(posedge clk);
  endtask

  task automatic pulse_start(input logic v, input logic [7:0] d);
    @(negedge clk);
    start    = 1'b1;
    in_valid = v;
    in_data  = d;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    vectors++;
    if (in_ready !== 1'b1 || prog_we !== 1'b0 || prog_addr !== 5'd0 || prog_wdata !== 19'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_data got rdy=%b we=%b addr=%0d wdata=%h, expected 1 0 0 0",
               in_ready, prog_we, prog_addr, prog_wdata);
    end
    vectors++;
    if (cpu_reset !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_status got cpu_reset=%b done=%b err=%b, expected 1 0 0",
               cpu_reset, done, err);
    end
  endtask

  // N=1 frame 01 23 45 / 67: one word then a 31-cycle zero fill
  task automatic test_single;
    bit first;
    int run;
    push_wr(0, 19'h12345);
    for (int k = 1; k < 32; k++) push_wr(k, 19'd0);
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    send_byte(8'h23, 0);
    send_byte(8'h45, 0);
    send_byte(8'h67, 0);
    first = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (prog_we) begin
        first = 1'b1;
        break;
      end
    end
    vectors++;
    if (!first) begin
      miscompares++;
      $display("[TB] FAIL fill_start got no write within 100 cycles, expected fill writes");
    end
    run = 1;
    while (run < 40) begin
      vectors++;
      if (done !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL early_done got done=%b during fill, expected 0", done);
      end
      @(negedge clk);
      if (!prog_we) break;
      run++;
    end
    vectors++;
    if (run != 31) begin
      miscompares++;
      $display("[TB] FAIL fill_run got %0d consecutive writes, expected 31", run);
    end
    vectors++;
    if (done !== 1'b1 || cpu_reset !== 1'b0 || err !== 1'b0 || in_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL single_done got done=%b cpu_reset=%b err=%b rdy=%b, expected 1 0 0 0",
               done, cpu_reset, err, in_ready);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL single_pending got %0d writes outstanding, expected 0", exp_q.size());
    end
  endtask

  // full 32-word image with in_valid toggling, no fill
  task automatic test_full;
    logic [18:0] w;
    logic [7:0]  chk;
    bit          fin;
    pulse_start(1'b0, 8'h00);
    chk = 8'h00;
    send_byte(8'd32, 1);
    for (int k = 0; k < 32; k++) begin
      w = 19'($urandom);
      push_wr(k, w);
      chk = chk ^ {5'd0, w[18:16]} ^ w[15:8] ^ w[7:0];
      send_byte({5'd0, w[18:16]}, 1);
      send_byte(w[15:8], 1);
      send_byte(w[7:0], 1);
    end
    send_byte(chk, 1);
    fin = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (done || err) begin
        fin = 1'b1;
        break;
      end
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (!fin || done !== 1'b1 || err !== 1'b0 || cpu_reset !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL full_done got done=%b err=%b cpu_reset=%b, expected 1 0 0", done, err, cpu_reset);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL full_pending got %0d writes outstanding, expected 0", exp_q.size());
    end
  endtask

  task automatic test_bad_chk;
    pulse_start(1'b0, 8'h00);
    push_wr(0, 19'h5A5A5);
    push_wr(1, 19'h0F00F);
    send_byte(8'h02, 0);
    send_byte(8'h05, 0);
    send_byte(8'hA5, 0);
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    send_byte(8'hF0, 0);
    send_byte(8'h0F, 0);
    send_byte(8'h05 ^ 8'hA5 ^ 8'hA5 ^ 8'hF0 ^ 8'h0F ^ 8'h01, 0);
    @(negedge clk);
    in_valid = 1'b0;
    vectors++;
    if (err !== 1'b1 || cpu_reset !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL bad_chk got err=%b cpu_reset=%b rdy=%b done=%b, expected 1 1 0 0",
               err, cpu_reset, in_ready, done);
    end
    repeat (40) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0 || err !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL bad_chk_hold got pending=%0d err=%b, expected 0 1", exp_q.size(), err);
    end
  endtask

  task automatic test_bad_count;
    logic [7:0] counts [2];
    counts[0] = 8'd0;
    counts[1] = 8'd33;
    for (int i = 0; i < 2; i++) begin
      pulse_start(1'b0, 8'h00);
      send_byte(counts[i], 0);
      @(negedge clk);
      in_valid = 1'b0;
      vectors++;
      if (err !== 1'b1 || in_ready !== 1'b0 || cpu_reset !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL bad_count got err=%b rdy=%b for count %0d, expected err=1 rdy=0",
                 err, in_ready, counts[i]);
      end
    end
    pulse_start(1'b0, 8'h00);
    send_byte(8'h01, 0);
    send_byte(8'h08, 0);
    @(negedge clk);
    in_valid = 1'b0;
    vectors++;
    if (err !== 1'b1 || done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL bad_b0 got err=%b done=%b, expected 1 0", err, done);
    end
    repeat (5) @(negedge clk);
  endtask

  // abort mid-word; the byte offered with start must be ignored
  task automatic test_start_abort;
    pulse_start(1'b0, 8'h00);
    push_wr(0, 19'h10203);
    send_byte(8'h02, 0);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    send_byte(8'h03, 0);
    send_byte(8'h04, 0);
    pulse_start(1'b1, 8'h01);
    vectors++;
    if (in_ready !== 1'b1 || cpu_reset !== 1'b1 || done !== 1'b0 || err !== 1'b0 || prog_we !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL after_start got rdy=%b cpu_reset=%b done=%b err=%b we=%b, expected 1 1 0 0 0",
               in_ready, cpu_reset, done, err, prog_we);
    end
    test_single();
  endtask

  task automatic test_async_reset;
    int seen;
    pulse_start(1'b0, 8'h00);
    push_wr(0, 19'h12345);
    for (int k = 1; k < 32; k++) push_wr(k, 19'd0);
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    send_byte(8'h23, 0);
    send_byte(8'h45, 0);
    send_byte(8'h67, 0);
    seen = 0;
    for (int c = 0; c < 100 && seen < 5; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (prog_we) seen++;
    end
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1 || prog_we !== 1'b0 || prog_addr !== 5'd0 || prog_wdata !== 19'd0 ||
        cpu_reset !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL async_reset got rdy=%b we=%b addr=%0d wdata=%h cpu_reset=%b done=%b err=%b, expected 1 0 0 0 1 0 0",
               in_ready, prog_we, prog_addr, prog_wdata, cpu_reset, done, err);
    end
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    test_single();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    start       = 1'b0;
    in_valid    = 1'b0;
    in_data     = 8'h00;
    repeat (2) @(negedge clk);
    test_reset();
    reset = 1'b1;
    test_single();
    test_full();
    test_bad_chk();
    test_bad_count();
    test_start_abort();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
